sreg_rr_serializer: RTL and testbench

- Controller that shares one WIDTH-bit serial shift register between two requesters.
- Arbitrates round-robin, parallel-loads the winner's word, shifts it out LSB-first on a single serial line, then returns a one-cycle acknowledge to the owner.
- Sits in front of the serial shift chain as its scheduler and sequencer.

---
 rtl/sreg_rr_serializer.sv | 84 ++++++++
 tb/tb_sreg_rr_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_rr_serializer.sv
// Round-robin scheduler for one shared WIDTH-bit serial shift register.
// Loads the winner's word, shifts it out LSB-first, then acks the owner.
module sreg_rr_serializer #(
  parameter int WIDTH = 8,
  parameter int CNTW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             sout,
  output logic             frame,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0]  cnt;
  logic             own_q;
  logic             last_owner;

  logic grant;
  logic win;

  assign grant = req0 | req1;
  // On a tie the requester that did not go last wins.
  assign win = (req0 & req1) ? ~last_owner : req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      own_q      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            shreg      <= win ? data1 : data0;
            own_q      <= win;
            last_owner <= win;
            cnt        <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {1'b0, shreg[WIDTH-1:1]};
          if (cnt == CNTW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign frame = (state == SHIFT);
  assign busy  = (state != IDLE);
  assign sout  = frame & shreg[0];
  assign ack0  = (state == DONE) & ~own_q;
  assign ack1  = (state == DONE) & own_q;
  assign owner = own_q;

endmodule

// File: tb/tb_sreg_rr_serializer.sv
// Bench for sreg_rr_serializer: table vectors, corner sequences
// and a random run against a frame-position reference model.
module tb_sreg_rr_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         req0;
  logic [W-1:0] data0;
  logic         req1;
  logic [W-1:0] data1;
  logic         ack0;
  logic         ack1;
  logic         sout;
  logic         frame;
  logic         busy;
  logic         owner;

  int ncmp = 0;
  int nbad = 0;

  sreg_rr_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .ack0  (ack0),
    .ack1  (ack1),
    .sout  (sout),
    .frame (frame),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {sout, frame, busy, ack0, ack1, owner};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b1;
  endtask

  // Waits (bounded) for frame, gathers W bits, returns ack/owner in DONE.
  task automatic capture(output logic [W-1:0] w, output logic o,
                         output logic a0, output logic a1,
                         output int lat, output logic fr_ok);
    int n;
    n     = 0;
    w     = '0;
    fr_ok = 1'b1;
    o     = 1'b0;
    a0    = 1'b0;
    a1    = 1'b0;
    @(negedge clk);
    while (!frame && n < 30) begin
      n++;
      @(negedge clk);
    end
    lat = n;
    if (!frame) begin
      chk("frame_timeout", 32'(frame), 32'h1);
      fr_ok = 1'b0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!frame || !busy) fr_ok = 1'b0;
        w[i] = sout;
        @(negedge clk);
      end
      a0 = ack0;
      a1 = ack1;
      o  = owner;
      if (frame || sout || !busy) fr_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] exp_word;
    logic         exp_own;
  } vec_t;

  vec_t vecs[6];

  // Reference model: position within a frame (0 idle, 1..W bits, W+1 ack)
  int           m_pos;
  logic [W-1:0] m_word;
  logic         m_own;
  logic         m_last;

  function automatic logic [5:0] m_outs();
    logic s, f, b, a0, a1;
    f  = (m_pos >= 1 && m_pos <= W);
    s  = f ? m_word[m_pos-1] : 1'b0;
    b  = (m_pos != 0);
    a0 = (m_pos == W + 1) && !m_own;
    a1 = (m_pos == W + 1) && m_own;
    return {s, f, b, a0, a1, m_own};
  endfunction

  task automatic m_step();
    if (m_pos == 0) begin
      if (req0 || req1) begin
        m_own  = (req0 && req1) ? !m_last : req1;
        m_last = m_own;
        m_word = m_own ? data1 : data0;
        m_pos  = 1;
      end
    end else if (m_pos <= W) begin
      m_pos++;
    end else begin
      m_pos = 0;
    end
  endtask

  initial begin
    logic [W-1:0] w;
    logic         o, a0, a1, fok;
    int           lat;
    logic         seen_ack;

    rst   = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 8'h3C, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 8'h0F, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'h34, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'hC3, 8'h81, 8'h81, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h55, 8'hAA, 8'h55, 1'b0};

    do_reset();

    // Idle line after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", 32'(outs()), 32'h0);
    end

    // Table vectors, each started from IDLE
    foreach (vecs[k]) begin
      req0  = vecs[k].r0;
      req1  = vecs[k].r1;
      data0 = vecs[k].d0;
      data1 = vecs[k].d1;
      capture(w, o, a0, a1, lat, fok);
      req0 = 1'b0;
      req1 = 1'b0;
      chk($sformatf("vec%0d_word", k), 32'(w), 32'(vecs[k].exp_word));
      chk($sformatf("vec%0d_owner", k), 32'(o), 32'(vecs[k].exp_own));
      chk($sformatf("vec%0d_ack", k), 32'({a0, a1}),
          32'({!vecs[k].exp_own, vecs[k].exp_own}));
      chk($sformatf("vec%0d_lat", k), 32'(lat), 32'd0);
      chk($sformatf("vec%0d_frame", k), 32'(fok), 32'd1);
      @(negedge clk);
    end

    // Both held for four frames: alternate owners, two-cycle gaps
    do_reset();
    data0 = 8'h0F;
    data1 = 8'hF0;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      capture(w, o, a0, a1, lat, fok);
      chk($sformatf("rr%0d_owner", f), 32'(o), 32'(f % 2));
      chk($sformatf("rr%0d_word", f), 32'(w), (f % 2) ? 32'hF0 : 32'h0F);
      chk($sformatf("rr%0d_ack", f), 32'({a0, a1}),
          (f % 2) ? 32'h1 : 32'h2);
      if (f > 0) chk($sformatf("rr%0d_gap", f), 32'(lat), 32'd1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

    // Drop req1 and change data1 on the third SHIFT cycle
    do_reset();
    req1  = 1'b1;
    data1 = 8'h81;
    @(negedge clk);
    chk("drop_frame_start", 32'(frame), 32'h1);
    w = '0;
    for (int i = 0; i < W; i++) begin
      w[i] = sout;
      if (i == 2) begin
        req1  = 1'b0;
        data1 = 8'h00;
      end
      @(negedge clk);
    end
    chk("drop_word", 32'(w), 32'h81);
    chk("drop_ack1", 32'({ack0, ack1}), 32'h1);

    // Reset during the fifth SHIFT cycle aborts the frame
    do_reset();
    req0  = 1'b1;
    data0 = 8'hFF;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("abort_pre", 32'({sout, frame, busy}), 32'h7);
    rst = 1'b0;
    #1;
    chk("abort_outs", 32'(outs()), 32'h0);
    req1     = 1'b1;
    data1    = 8'h66;
    seen_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen_ack = 1'b1;
    end
    chk("abort_no_ack", 32'(seen_ack), 32'h0);
    data0 = 8'h3A;
    rst   = 1'b1;
    capture(w, o, a0, a1, lat, fok);
    chk("abort_regrant_owner", 32'(o), 32'h0);
    chk("abort_regrant_word", 32'(w), 32'h3A);
    req0 = 1'b0;
    req1 = 1'b0;

    // Random run against the reference model
    do_reset();
    m_pos  = 0;
    m_word = '0;
    m_own  = 1'b0;
    m_last = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      chk("rand_outs", 32'(outs()), 32'(m_outs()));
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      data0 = W'($urandom);
      data1 = W'($urandom);
      m_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
